// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Types and constants shared by the RV32I pipeline control blocks.
//   fwd_sel_e     : EX operand forwarding select encoding
//   slot_t        : per-stage destination-tracking record
//   hazard_act_e  : resolved pipeline-control action for the current cycle
//   is_producer() : true when a slot will write a forwardable result
// ---------------------------------------------------------------------------
package rv_pkg;

   localparam int REG_AW = 5;

   // Operand mux select: register file, WB-stage result, MEM-stage ALU result.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Destination tracking for one in-flight instruction.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

   // Pipeline-control decision, listed from highest to lowest priority.
   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_HOLD,
      ACT_REDIRECT,
      ACT_LOAD_USE
   } hazard_act_e;

   // x0 is hard-wired to zero, so a write to it never produces a value.
   function automatic logic is_producer(input slot_t s);
      return s.valid && s.regwrite && (s.rd != '0);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Forwarding and load-use detection for one ID-stage source operand.
//   rs        in  source register number
//   use_rs    in  the ID instruction actually reads rs
//   ex_slot   in  tracking record of the instruction now in EX
//   mem_slot  in  tracking record of the instruction now in MEM
//   fwd_sel   out select to latch for this operand when it enters EX
//   load_use  out the EX instruction is a load whose result rs needs
// ---------------------------------------------------------------------------
module fwd_match
   import rv_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic              use_rs,
   input  slot_t             ex_slot,
   input  slot_t             mem_slot,
   output fwd_sel_e          fwd_sel,
   output logic              load_use
);

   logic ex_hit;
   logic mem_hit;

   // The memread flag of the MEM slot does not matter here: by the time a
   // load reaches MEM its data is on the WB-stage result path.
   logic unused_mem_memread;
   assign unused_mem_memread = mem_slot.memread;

   assign ex_hit  = use_rs && is_producer(ex_slot)  && (ex_slot.rd  == rs);
   assign mem_hit = use_rs && is_producer(mem_slot) && (mem_slot.rd == rs);

   // The instruction now in EX will be in MEM when the consumer reaches EX,
   // so it is the newest producer and takes priority over the MEM slot.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path through the if/else leaves it unassigned (latch).
      fwd_sel = FWD_RF;
      if (ex_hit) begin
         fwd_sel = FWD_MEM;
      end else if (mem_hit) begin
         fwd_sel = FWD_WB;
      end
   end

   // A load's data only exists after MEM, so a dependent instruction right
   // behind it must wait one cycle. Writes to x0 never create a hazard.
   assign load_use = use_rs && ex_slot.valid && ex_slot.memread &&
                     (ex_slot.rd != '0) && (ex_slot.rd == rs);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage RV32I pipeline. Shadows
// the destination of every in-flight instruction (EX/MEM/WB), registers the
// EX operand forwarding selects, and drives stall/flush/bubble for load-use
// hazards and EX-resolved redirects.
//   clk, rst                      pipeline clock, synchronous active-high reset
//   hold                          global freeze; all state holds
//   id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_regwrite, id_memread
//                                 decoded ID-stage instruction
//   ex_redirect                   taken branch/jump resolved in EX
//   stall                         hold PC and IF/ID (combinational)
//   flush_id                      squash IF/ID (combinational)
//   bubble_ex                     load NOP into ID/EX (combinational)
//   fwd_a, fwd_b                  registered EX operand selects
//   stall_cnt, flush_cnt          load-use stall cycles / redirects taken
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
   import rv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_redirect,
   output logic              stall,
   output logic              flush_id,
   output logic              bubble_ex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   slot_t       id_slot;
   slot_t       ex_next;
   slot_t       ex_slot;
   slot_t       mem_slot;
   slot_t       wb_slot;
   fwd_sel_e    sel_a;
   fwd_sel_e    sel_b;
   fwd_sel_e    fwd_a_q;
   fwd_sel_e    fwd_b_q;
   logic        hit_a;
   logic        hit_b;
   logic        load_use;
   hazard_act_e act;

   // -------------------------------------------------------------------------
   // Per-operand forwarding / load-use detection
   // -------------------------------------------------------------------------
   fwd_match u_match_rs1 (
      .rs       (id_rs1),
      .use_rs   (id_use_rs1),
      .ex_slot  (ex_slot),
      .mem_slot (mem_slot),
      .fwd_sel  (sel_a),
      .load_use (hit_a)
   );

   fwd_match u_match_rs2 (
      .rs       (id_rs2),
      .use_rs   (id_use_rs2),
      .ex_slot  (ex_slot),
      .mem_slot (mem_slot),
      .fwd_sel  (sel_b),
      .load_use (hit_b)
   );

   assign load_use = id_valid && (hit_a || hit_b);

   // -------------------------------------------------------------------------
   // Control priority: a freeze beats everything; a redirect squashes the
   // consumer anyway, so it beats load-use.
   // -------------------------------------------------------------------------
   always_comb begin
      act = ACT_NONE;
      if (hold) begin
         act = ACT_HOLD;
      end else if (ex_redirect) begin
         act = ACT_REDIRECT;
      end else if (load_use) begin
         act = ACT_LOAD_USE;
      end
   end

   always_comb begin
      stall     = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      unique case (act)
         ACT_HOLD: begin
            // Freeze: nothing moves, so nothing needs to be bubbled.
            stall = 1'b1;
         end
         ACT_REDIRECT: begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
         end
         ACT_LOAD_USE: begin
            // Keep the consumer in ID one cycle and send a bubble behind the load.
            stall     = 1'b1;
            bubble_ex = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next EX slot
   // -------------------------------------------------------------------------
   always_comb begin
      id_slot = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      ex_next = id_slot;
      if (bubble_ex || !id_valid) begin
         ex_next = SLOT_EMPTY;
      end
   end

   // The WB slot is tracked so the shadow pipeline mirrors the real one, but
   // nothing reads it: a WB-stage producer is bypassed inside the register
   // file, so an ID consumer selects the register file path.
   logic unused_wb;
   assign unused_wb = ^wb_slot;

   // -------------------------------------------------------------------------
   // Shadow slots, select registers and counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot   <= SLOT_EMPTY;
         mem_slot  <= SLOT_EMPTY;
         wb_slot   <= SLOT_EMPTY;
         fwd_a_q   <= FWD_RF;
         fwd_b_q   <= FWD_RF;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!hold) begin
         // NOTE: non-blocking assignments make the slot shift read the old
         // value of every stage, so the three stages advance together.
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         ex_slot  <= ex_next;
         // A bubble entering EX must not steer the operand muxes.
         fwd_a_q  <= ex_next.valid ? sel_a : FWD_RF;
         fwd_b_q  <= ex_next.valid ? sel_b : FWD_RF;
         if (act == ACT_LOAD_USE) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (act == ACT_REDIRECT) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed scoreboard bench. Each cycle the stimulus process drives one ID
// instruction shortly after the rising edge and queues the expected outputs
// for that cycle: combinational stall/flush/bubble for these inputs, and the
// registered selects/counters produced by the preceding edge. A monitor on
// the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;
   import rv_pkg::*;

   localparam int CNT_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              hold;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              ex_redirect;
   logic              stall;
   logic              flush_id;
   logic              bubble_ex;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .hold        (hold),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .ex_redirect (ex_redirect),
      .stall       (stall),
      .flush_id    (flush_id),
      .bubble_ex   (bubble_ex),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } ins_t;

   typedef struct {
      string      nm;
      logic       st;
      logic       fl;
      logic       bu;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ins_t i;
      i = '{v: 1'b1, rs1: rs1, u1: 1'b1, rs2: rs2, u2: 1'b1, rd: rd, rw: 1'b1, mr: 1'b0};
      return i;
   endfunction

   function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] rs1);
      ins_t i;
      i = '{v: 1'b1, rs1: rs1, u1: 1'b1, rs2: 5'd0, u2: 1'b0, rd: rd, rw: 1'b1, mr: 1'b1};
      return i;
   endfunction

   function automatic ins_t nop();
      ins_t i;
      i = '{v: 1'b0, rs1: 5'd0, u1: 1'b0, rs2: 5'd0, u2: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
      return i;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One pipeline cycle: drive inputs, queue what the monitor should see.
   task automatic cyc(input string nm, input ins_t i, input logic redir, input logic hld,
                      input logic r, input logic est, input logic efl, input logic ebu,
                      input logic [1:0] efa, input logic [1:0] efb,
                      input int esc, input int efc);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      hold        = hld;
      ex_redirect = redir;
      id_valid    = i.v;
      id_rs1      = i.rs1;
      id_use_rs1  = i.u1;
      id_rs2      = i.rs2;
      id_use_rs2  = i.u2;
      id_rd       = i.rd;
      id_regwrite = i.rw;
      id_memread  = i.mr;
      e = '{nm: nm, st: est, fl: efl, bu: ebu, fa: efa, fb: efb, sc: esc, fc: efc};
      sbq.push_back(e);
   endtask

   // Monitor: sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         check({e.nm, ".stall"},     {31'd0, stall},     {31'd0, e.st});
         check({e.nm, ".flush_id"},  {31'd0, flush_id},  {31'd0, e.fl});
         check({e.nm, ".bubble_ex"}, {31'd0, bubble_ex}, {31'd0, e.bu});
         check({e.nm, ".fwd_a"},     {30'd0, fwd_a},     {30'd0, e.fa});
         check({e.nm, ".fwd_b"},     {30'd0, fwd_b},     {30'd0, e.fb});
         check({e.nm, ".stall_cnt"}, stall_cnt,          e.sc);
         check({e.nm, ".flush_cnt"}, flush_cnt,          e.fc);
      end
   end

   initial begin
      rst = 1'b1; hold = 1'b0; ex_redirect = 1'b0;
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //   name             instr             rdr  hld  rst  st fl bu  fa     fb    sc fc
      cyc("reset_state",    nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      // back-to-back ALU dependency -> MEM forward
      cyc("b2b_prod",       alu(5, 1, 2),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("b2b_cons",       alu(6, 5, 3),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("b2b_ex",         nop(),            0,   0,   0,   0, 0, 0, 2'b10, 2'b00, 0, 0);
      // one nop gap -> WB forward on operand B
      cyc("gap1_prod",      alu(5, 1, 2),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap1_nop",       nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap1_cons",      alu(7, 4, 5),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap1_ex",        nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b01, 0, 0);
      // two nop gap -> register file
      cyc("gap2_prod",      alu(5, 1, 2),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap2_nop1",      nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap2_nop2",      nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap2_cons",      alu(7, 4, 5),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("gap2_ex",        nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      // load-use: one stall cycle, then WB forward
      cyc("lu_load",        ld(6, 1),         0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("lu_stall",       alu(7, 6, 1),     0,   0,   0,   1, 0, 1, 2'b00, 2'b00, 0, 0);
      cyc("lu_retry",       alu(7, 6, 1),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("lu_ex",          nop(),            0,   0,   0,   0, 0, 0, 2'b01, 2'b00, 1, 0);
      // producers of x5 in both EX and MEM: newest wins
      cyc("newest_p1",      alu(5, 1, 2),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("newest_p2",      alu(5, 3, 4),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("newest_cons",    alu(8, 5, 1),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("newest_ex",      nop(),            0,   0,   0,   0, 0, 0, 2'b10, 2'b00, 1, 0);
      // same with x0: never forwards, never stalls, including after lw x0
      cyc("x0_p1",          alu(0, 1, 2),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("x0_p2",          alu(0, 3, 4),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("x0_cons",        alu(8, 0, 0),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("x0_load",        ld(0, 1),         0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("x0_ld_cons",     alu(9, 0, 0),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("x0_ex",          nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      // redirect overrides load-use
      cyc("rd_load",        ld(6, 1),         0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 0);
      cyc("rd_redirect",    alu(7, 6, 1),     1,   0,   0,   0, 1, 1, 2'b00, 2'b00, 1, 0);
      cyc("rd_after",       alu(1, 2, 3),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 1);
      // hold for 3 cycles in a load-use window; redirect during hold ignored
      cyc("hold_load",      ld(6, 1),         0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 1, 1);
      cyc("hold_1",         alu(7, 6, 1),     0,   1,   0,   1, 0, 0, 2'b10, 2'b00, 1, 1);
      cyc("hold_2_redir",   alu(7, 6, 1),     1,   1,   0,   1, 0, 0, 2'b10, 2'b00, 1, 1);
      cyc("hold_3",         alu(7, 6, 1),     0,   1,   0,   1, 0, 0, 2'b10, 2'b00, 1, 1);
      cyc("hold_rel_stall", alu(7, 6, 1),     0,   0,   0,   1, 0, 1, 2'b10, 2'b00, 1, 1);
      cyc("hold_retry",     alu(7, 6, 1),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 2, 1);
      cyc("hold_ex",        nop(),            0,   0,   0,   0, 0, 0, 2'b01, 2'b00, 2, 1);
      // rst asserted mid-stall clears everything on the next edge
      cyc("rst_load",       ld(6, 1),         0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 2, 1);
      cyc("rst_in_stall",   alu(7, 6, 1),     0,   0,   1,   1, 0, 1, 2'b00, 2'b00, 2, 1);
      cyc("rst_after",      alu(7, 6, 1),     0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);
      cyc("rst_ex",         nop(),            0,   0,   0,   0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Bounded drain of the scoreboard.
      for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Hazard and forwarding controller for the 5-stage RV32I pipeline. It tracks the destination register of every in-flight instruction in its own EX/MEM/WB shadow slots and generates the registered forwarding selects for the EX-stage ALU operand A and operand B/rs2 muxes. It also detects load-use hazards and squashes on EX-resolved redirects, driving stall/flush to the IF/ID and ID/EX pipeline registers. It sits beside the decode stage and feeds the operand muxes ahead of the immediate/register select.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze, e.g. memory wait; all state holds.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2. rs2 counts even when the immediate is selected, for stores.
- id_rd  in  5  ID destination.
- id_regwrite  in  1  ID writes rd.
- id_memread  in  1  ID is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- flush_id  out  1  squash the IF/ID register (combinational).
- bubble_ex  out  1  load NOP into ID/EX (combinational).
- fwd_a, fwd_b  out  2  registered operand selects for the EX instruction.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirects taken.

## Operation
- Shadow slots EX, MEM, WB each hold {valid, rd, regwrite, memread}.
- Every cycle with hold=0: WB<=MEM, MEM<=EX, EX<=ID info. EX instead takes an invalid bubble when bubble_ex=1 or id_valid=0.
- A producer is a valid slot with regwrite=1 and rd!=0. x0 never forwards and never stalls.
- Forward encoding: 00 register file, 01 WB-stage result, 10 MEM-stage ALU result.
- fwd_x is computed in ID for source rsx with use=1 and latched into the EX select register:
  - 10 if the EX slot is a producer with rd==rsx.
  - Otherwise 01 if the MEM slot is a producer with rd==rsx.
  - Otherwise 00.
  - The newest producer always wins.
- A producer in the WB slot while the consumer is in ID yields 00. The register file bypasses the same-cycle write internally.
- Load-use condition: id_valid, EX slot valid with memread=1, rd!=0, and rd matches a used source.
  - Result: stall=1, bubble_ex=1, flush_id=0, for exactly one cycle.
  - Next cycle the load sits in MEM, and the consumer latches fwd=01.
- Redirect, with ex_redirect=1 and hold=0: flush_id=1, bubble_ex=1, stall=0.
  - Redirect overrides load-use.
  - The branch itself advances to MEM normally.
- hold=1:
  - Slots, fwd registers and counters keep their values.
  - stall=1, flush_id=0, bubble_ex=0.
  - ex_redirect is ignored and must be re-presented after hold drops.
- Counters:
  - stall_cnt increments on each load-use stall cycle with hold=0.
  - flush_cnt increments on each accepted redirect.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset values: all slots invalid, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0. stall, flush_id and bubble_ex evaluate to 0 after reset.
- stall, flush_id and bubble_ex are combinational from the ID inputs and slot state. They are valid in the same cycle and must settle before the clk edge.
- fwd_a/fwd_b change only on clk edges and are valid for the whole EX cycle of the instruction they belong to. On a bubble they are 00.
- Load-use costs exactly 1 cycle. Redirect costs 2 squashed instructions (IF/ID and ID/EX).
- rst asserted mid-stall or mid-hold: the next edge clears everything. No hazard is carried over.

## Structure
- Shared package rv_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW=5.
  - Slot struct/typedef {valid, rd, regwrite, memread}.
- Sub-module fwd_match: one per source operand. Inputs are rs, use, EX slot and MEM slot; outputs are the 2-bit select plus a load-use hit flag. It is instantiated twice (rs1, rs2).
- Top level holds the slot registers, select registers, stall/flush priority logic and counters.

## Test plan
- add x5,x1,x2 then add x6,x5,x3 back-to-back: consumer EX cycle shows fwd_a=10, no stall.
- add x5 then nop then sub x7,x4,x5: fwd_b=01. With two nops: fwd_b=00.
- lw x6,0(x1) then add x7,x6,x1:
  - stall=1 and bubble_ex=1 for one cycle.
  - Consumer then shows fwd_a=01.
  - stall_cnt=1.
- Producers of x5 in both EX and MEM slots, consumer reads x5: fwd_a=10. Same sequence with rd=x0: fwd 00 and no stall, including after a load to x0.
- Load-use present while ex_redirect=1:
  - stall=0, flush_id=1, bubble_ex=1.
  - flush_cnt=1, stall_cnt unchanged.
- hold=1 for 3 cycles during a load-use window: slots, fwd and counters are frozen and stall=1. After release exactly one load-use stall cycle occurs. rst pulsed mid-sequence zeroes all outputs and counters.
